// File: rtl/lead_tuner.sv
// lead_tuner: averages feedback half-periods and loads shift = avg - lead (clamped) into the predictor.
// Optional LEAD_TUNER_SLEW_EN limits each tracking update to +/-SLEW from the previous shift.
module lead_tuner #(
  parameter int PRED_PARAMETER = 255,
  parameter int TIMEOUT = 1023,
  parameter int AVG_LOG2 = 2,
  parameter int MIN_SHIFT = 1,
  parameter int SLEW = 4,
  localparam int W = $clog2(PRED_PARAMETER + 1),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          fb,
  input  logic [W-1:0]  lead,
  output logic [W-1:0]  shift,
  output logic          shift_vld,
  output logic          locked,
  output logic          fault,
  output logic [CW-1:0] half_period
);
  localparam int AW = CW + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam int XW = CW + 1;
  typedef enum logic [1:0] {IDLE, ACQ, TRACK, FAULT} state_t;
  state_t state, state_nx;
  logic fb_d, first, fb_edge, tmo, run, sample, done;
  logic [CW-1:0] hp_cnt, avg;
  logic [AW-1:0] acc, acc_sum;
  logic [NW-1:0] cnt;
  logic [XW-1:0] lead_x, diff;
  logic [W-1:0] calc, nxt_shift;
`ifdef LEAD_TUNER_SLEW_EN
  logic [W-1:0] lo, hi;
`endif
  always_comb begin
    fb_edge = fb ^ fb_d;
    tmo = hp_cnt == CW'(TIMEOUT);
    run = state == ACQ || state == TRACK;
    // the first edge after entering ACQ closes a partial period and is not a sample
    sample = run && en && !tmo && fb_edge && !first;
    acc_sum = acc + AW'(hp_cnt);
    done = sample && cnt == NW'((1 << AVG_LOG2) - 1);
    avg = CW'(acc_sum >> AVG_LOG2);
    lead_x = XW'(lead);
    diff = XW'(avg) - lead_x;
    calc = (XW'(avg) <= lead_x + XW'(MIN_SHIFT)) ? W'(MIN_SHIFT) :
           (diff > XW'(PRED_PARAMETER)) ? W'(PRED_PARAMETER) : W'(diff);
`ifdef LEAD_TUNER_SLEW_EN
    lo = (shift < W'(MIN_SHIFT + SLEW)) ? W'(MIN_SHIFT) : shift - W'(SLEW);
    hi = ((W+1)'(shift) + (W+1)'(SLEW) > (W+1)'(PRED_PARAMETER)) ? W'(PRED_PARAMETER) : shift + W'(SLEW);
    nxt_shift = state != TRACK ? calc : calc < lo ? lo : calc > hi ? hi : calc;
`else
    nxt_shift = calc;
`endif
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = en ? ACQ : IDLE;
      ACQ, TRACK: state_nx = !en ? IDLE : tmo ? FAULT : done ? TRACK : state;
      FAULT:      state_nx = en ? FAULT : IDLE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  assign locked = state == TRACK;
  assign fault = state == FAULT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_d <= 1'b0;
      hp_cnt <= '0;
      acc <= '0;
      cnt <= '0;
      first <= 1'b1;
      shift <= W'(PRED_PARAMETER);
      shift_vld <= 1'b0;
      half_period <= '0;
    end else begin
      fb_d <= fb;
      hp_cnt <= fb_edge ? CW'(1) : tmo ? hp_cnt : hp_cnt + CW'(1);
      shift_vld <= done;
      if (done) begin
        shift <= nxt_shift;
        half_period <= avg;
      end
      // outside ACQ/TRACK any partial block is dropped and the next entry re-arms the discard
      if (!run) begin
        acc <= '0;
        cnt <= '0;
        first <= 1'b1;
      end else begin
        if (fb_edge) first <= 1'b0;
        if (sample) begin
          acc <= done ? '0 : acc_sum;
          cnt <= done ? '0 : cnt + NW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_lead_tuner.sv
// tb_lead_tuner: randomized bench checking lead_tuner every cycle against a block-average model.
module tb_lead_tuner;
  localparam int PRED = 255, TMO = 1023, NAVG = 4, MINS = 1, SLEW = 4;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, fb = 1'b0;
  logic [7:0] lead = 8'd0;
  logic [7:0] shift;
  logic shift_vld, locked, fault;
  logic [9:0] half_period;
  int tests = 0, fails = 0;

  lead_tuner dut (.clk(clk), .rst_n(rst_n), .en(en), .fb(fb), .lead(lead), .shift(shift),
                  .shift_vld(shift_vld), .locked(locked), .fault(fault), .half_period(half_period));

  always #5 clk = ~clk;

  // model: mode 0 idle, 1 acquiring, 2 tracking, 3 fault
  int m_mode = 0, since = 0, e_shift = PRED, e_hp = 0;
  bit armed = 0, skip = 1, m_prev = 0, e_vld = 0;
  int q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int target(input int avg, input int ld);
    if (avg <= ld + MINS) return MINS;
    return (avg - ld > PRED) ? PRED : avg - ld;
  endfunction

  task automatic model_step();
    bit edg;
    int sum, nv;
    e_vld = 0;
    if (!rst_n) begin
      armed = 1; m_mode = 0; e_shift = PRED; e_hp = 0; since = 0; m_prev = 0;
      q.delete();
      return;
    end
    if (!armed) return;
    edg = fb != m_prev;
    case (m_mode)
      0: if (en) begin m_mode = 1; skip = 1; q.delete(); end
      1, 2: begin
        if (!en) m_mode = 0;
        else if (since == TMO) m_mode = 3;
        else if (edg) begin
          if (skip) skip = 0;
          else begin
            q.push_back(since);
            if (q.size() == NAVG) begin
              sum = 0;
              foreach (q[i]) sum += q[i];
              nv = target(sum / NAVG, int'(lead));
`ifdef LEAD_TUNER_SLEW_EN
              if (m_mode == 2) begin
                if (nv > e_shift + SLEW) nv = e_shift + SLEW;
                if (nv < e_shift - SLEW) nv = e_shift - SLEW;
              end
`endif
              e_shift = nv; e_hp = sum / NAVG; e_vld = 1; m_mode = 2;
              q.delete();
            end
          end
        end
      end
      default: if (!en) m_mode = 0;
    endcase
    since = edg ? 1 : (since < TMO ? since + 1 : TMO);
    m_prev = fb;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("shift", 32'(shift), 32'(e_shift));
      chk("shift_vld", 32'(shift_vld), 32'(e_vld));
      chk("locked", 32'(locked), 32'(m_mode == 2));
      chk("fault", 32'(fault), 32'(m_mode == 3));
      chk("half_period", 32'(half_period), 32'(e_hp));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hp(input int p);
    cyc(p);
    fb = ~fb;
  endtask

  initial begin
    int p;
    cyc(2);
    chk("reset shift", 32'(shift), 255);
    chk("reset locked", 32'(locked), 0);
    chk("reset fault", 32'(fault), 0);
    chk("reset half_period", 32'(half_period), 0);
    rst_n = 1; en = 1; lead = 8'd10;
    repeat (5) hp(100);
    cyc(1);
    chk("first lock vld", 32'(shift_vld), 1);
    chk("first lock shift", 32'(shift), 90);
    chk("first lock locked", 32'(locked), 1);
    chk("first lock half_period", 32'(half_period), 100);
    for (int i = 0; i < 8; i++) hp(i % 2 ? 101 : 99);
    cyc(1);
    chk("jitter vld", 32'(shift_vld), 1);
    chk("jitter shift", 32'(shift), 90);
    cyc(1030);
    chk("timeout fault", 32'(fault), 1);
    chk("timeout locked", 32'(locked), 0);
    chk("timeout shift held", 32'(shift), 90);
    en = 0;
    cyc(2);
    chk("fault cleared", 32'(fault), 0);
    repeat (2) hp(100);
    en = 1;
    repeat (5) hp(100);
    cyc(1);
    chk("reacquire locked", 32'(locked), 1);
    chk("reacquire shift", 32'(shift), 90);
    repeat (40) hp(60);
    cyc(1);
    chk("step shift", 32'(shift), 50);
    lead = 8'd120;
    repeat (56) hp(100);
    cyc(1);
    chk("min clamp shift", 32'(shift), 1);
    lead = 8'd10;
    repeat (4) hp(400);
    cyc(1);
    chk("long half_period", 32'(half_period), 400);
    rst_n = 0;
    cyc(1);
    chk("midtrack reset shift", 32'(shift), 255);
    chk("midtrack reset locked", 32'(locked), 0);
    rst_n = 1;
    repeat (5) hp(100);
    cyc(1);
    chk("post reset locked", 32'(locked), 1);
    chk("post reset shift", 32'(shift), 90);
    repeat (150) begin
      p = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1000, 1030)) : int'($urandom_range(20, 260));
      lead = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) begin
        en = 0;
        cyc(int'($urandom_range(1, 5)));
        en = 1;
      end
      hp(p);
    end
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
